// File: rtl/judge_round.sv
// Per-round referee: latches a question, checks the player's factor entries, races
// them against a level-scaled enemy timer and a round limit, and emits a one-cycle verdict.
module judge_round #(
    parameter logic [15:0] TIME_LIMIT = 16'd200,
    parameter logic [15:0] ENEMY_BASE = 16'd160,
    parameter logic [15:0] ENEMY_STEP = 16'd40
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [35:0] DB_IN,
    input  logic [7:0]  MY_FACT,
    input  logic        MY_VALID,
    input  logic        MY_SUBMIT,
    input  logic        GAME_OVER,
    output logic [2:0]  JUDGE_OUT,
    output logic        WRONG,
    output logic        BUSY,
    output logic [15:0] TIME_LEFT
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [1:0]      level;
        logic [1:0]      cnt_m1;
        logic [3:0][7:0] fact;
    } question_t;

    localparam logic [2:0] V_PLAYER = 3'b001;
    localparam logic [2:0] V_ENEMY  = 3'b010;
    localparam logic [2:0] V_DRAW   = 3'b011;

    question_t       q_in;
    logic [15:0]     lvl;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0][7:0] fact_q, fact_d;
    logic [15:0]     e_q, e_d;
    logic [15:0]     t_q, t_d;
    logic [2:0]      idx_q, idx_d;
    logic            mis_q, mis_d;
    logic [2:0]      judge_q, judge_d;
    logic            wrong_q, wrong_d;

    logic [2:0]      ent_idx;
    logic            ent_mis;
    logic            correct, bad_submit, enemy, tmo;

    assign q_in = DB_IN;
    // Level 0 plays like level 1.
    assign lvl  = (q_in.level == 2'd0) ? 16'd1 : {14'd0, q_in.level};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fact_d     = fact_q;
        e_d        = e_q;
        t_d        = t_q;
        idx_d      = idx_q;
        mis_d      = mis_q;
        judge_d    = 3'b000;
        wrong_d    = 1'b0;
        ent_idx    = idx_q;
        ent_mis    = mis_q;
        correct    = 1'b0;
        bad_submit = 1'b0;
        enemy      = 1'b0;
        tmo        = 1'b0;
        case (state_q)
            IDLE: begin
                t_d   = '0;
                idx_d = '0;
                mis_d = 1'b0;
                if (START && !GAME_OVER) begin
                    cnt_d   = q_in.cnt_m1;
                    fact_d  = q_in.fact;
                    e_d     = ENEMY_BASE - lvl * ENEMY_STEP;
                    t_d     = TIME_LIMIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (GAME_OVER) begin
                    state_d = IDLE;
                    t_d     = '0;
                end else begin
                    // Entry is folded in before the submit so a same-cycle last factor counts.
                    if (MY_VALID) begin
                        if (idx_q == 3'd4) begin
                            ent_mis = 1'b1;
                        end else begin
                            if (MY_FACT != fact_q[idx_q[1:0]]) ent_mis = 1'b1;
                            ent_idx = idx_q + 3'd1;
                        end
                    end
                    correct    = MY_SUBMIT && !ent_mis && (ent_idx == ({1'b0, cnt_q} + 3'd1));
                    bad_submit = MY_SUBMIT && !correct;
                    idx_d      = bad_submit ? 3'd0 : ent_idx;
                    mis_d      = bad_submit ? 1'b0 : ent_mis;
                    wrong_d    = bad_submit;

                    enemy = (e_q == 16'd1);
                    if (!enemy) e_d = e_q - 16'd1;
                    tmo   = (t_q == 16'd1);
                    if (!tmo) t_d = t_q - 16'd1;

                    if (correct && enemy) judge_d = V_DRAW;
                    else if (correct)     judge_d = V_PLAYER;
                    else if (enemy)       judge_d = V_ENEMY;
                    else if (tmo)         judge_d = V_DRAW;
                    if (correct || enemy || tmo) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                t_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fact_q  <= '0;
            e_q     <= '0;
            t_q     <= '0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            judge_q <= 3'b000;
            wrong_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fact_q  <= fact_d;
            e_q     <= e_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            judge_q <= judge_d;
            wrong_q <= wrong_d;
        end
    end

    assign JUDGE_OUT = judge_q;
    assign WRONG     = wrong_q;
    assign BUSY      = (state_q != IDLE);
    assign TIME_LEFT = t_q;

endmodule

// File: tb/tb_judge_round.sv
// Scoreboarded bench for judge_round: default-parameter instance A and a
// short-round instance B (TIME_LIMIT=30) sharing all inputs except START.
module tb_judge_round;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start_a, start_b;
    logic [35:0] DB_IN;
    logic [7:0]  MY_FACT;
    logic        MY_VALID, MY_SUBMIT, GAME_OVER;
    logic [2:0]  judge_a, judge_b;
    logic        wrong_a, wrong_b, busy_a, busy_b;
    logic [15:0] tl_a, tl_b;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [2:0] judge;
        logic       wrong;
        string      tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    judge_round u_a (
        .CLK(CLK), .RST(RST), .START(start_a), .DB_IN(DB_IN), .MY_FACT(MY_FACT),
        .MY_VALID(MY_VALID), .MY_SUBMIT(MY_SUBMIT), .GAME_OVER(GAME_OVER),
        .JUDGE_OUT(judge_a), .WRONG(wrong_a), .BUSY(busy_a), .TIME_LEFT(tl_a)
    );

    judge_round #(.TIME_LIMIT(16'd30)) u_b (
        .CLK(CLK), .RST(RST), .START(start_b), .DB_IN(DB_IN), .MY_FACT(MY_FACT),
        .MY_VALID(MY_VALID), .MY_SUBMIT(MY_SUBMIT), .GAME_OVER(GAME_OVER),
        .JUDGE_OUT(judge_b), .WRONG(wrong_b), .BUSY(busy_b), .TIME_LEFT(tl_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every nonzero verdict/WRONG cycle must match the oldest expected event.
    always @(negedge CLK) begin
        exp_t e;
        if (judge_a != 3'b000 || wrong_a) begin
            if (qa.size() == 0) chk("A_spurious", {28'd0, judge_a, wrong_a}, 32'd0);
            else begin
                e = qa.pop_front();
                chk({e.tag, "_cyc"}, cyc, e.cyc);
                chk({e.tag, "_judge"}, {29'd0, judge_a}, {29'd0, e.judge});
                chk({e.tag, "_wrong"}, {31'd0, wrong_a}, {31'd0, e.wrong});
            end
        end
        if (judge_b != 3'b000 || wrong_b) begin
            if (qb.size() == 0) chk("B_spurious", {28'd0, judge_b, wrong_b}, 32'd0);
            else begin
                e = qb.pop_front();
                chk({e.tag, "_cyc"}, cyc, e.cyc);
                chk({e.tag, "_judge"}, {29'd0, judge_b}, {29'd0, e.judge});
                chk({e.tag, "_wrong"}, {31'd0, wrong_b}, {31'd0, e.wrong});
            end
        end
    end

    task automatic push_a(input int c, input logic [2:0] j, input logic w, input string tag);
        exp_t e;
        e.cyc = c; e.judge = j; e.wrong = w; e.tag = tag;
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input logic [2:0] j, input logic w, input string tag);
        exp_t e;
        e.cyc = c; e.judge = j; e.wrong = w; e.tag = tag;
        qb.push_back(e);
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic start_round(input logic which_b, input logic [35:0] db, output int t);
        DB_IN = db;
        if (which_b) start_b = 1'b1; else start_a = 1'b1;
        t = cyc;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic enter(input logic [7:0] f, input logic sub);
        MY_VALID  = 1'b1;
        MY_FACT   = f;
        MY_SUBMIT = sub;
        step();
        MY_VALID  = 1'b0;
        MY_SUBMIT = 1'b0;
    endtask

    task automatic submit(output int s);
        s = cyc;
        MY_SUBMIT = 1'b1;
        step();
        MY_SUBMIT = 1'b0;
    endtask

    localparam logic [35:0] Q_L1 = {2'd1, 2'd2, 8'd0, 8'd7, 8'd5, 8'd3};
    localparam logic [35:0] Q_L2 = {2'd2, 2'd2, 8'd0, 8'd7, 8'd5, 8'd3};
    localparam logic [35:0] Q_L3 = {2'd3, 2'd0, 8'd0, 8'd0, 8'd0, 8'd9};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s;
        RST = 1'b1; start_a = 0; start_b = 0; DB_IN = '0; MY_FACT = '0;
        MY_VALID = 0; MY_SUBMIT = 0; GAME_OVER = 0;
        repeat (3) step();
        chk("rst_judge", {29'd0, judge_a}, 32'd0);
        chk("rst_wrong", {31'd0, wrong_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_time", {16'd0, tl_a}, 32'd0);
        RST = 1'b0;
        step();

        // Straight correct answer.
        start_round(1'b0, Q_L1, t);
        chk("t1_time_start", {16'd0, tl_a}, 32'd200);
        chk("t1_busy", {31'd0, busy_a}, 32'd1);
        enter(8'd3, 0); enter(8'd5, 0); enter(8'd7, 0);
        push_a(t + 5, 3'b001, 1'b0, "t1_win");
        submit(s);
        chk("t1_busy_done", {31'd0, busy_a}, 32'd1);
        step();
        chk("t1_busy_low", {31'd0, busy_a}, 32'd0);
        chk("t1_time_idle", {16'd0, tl_a}, 32'd0);
        step();

        // Wrong order, then correct retry.
        start_round(1'b0, Q_L1, t);
        enter(8'd3, 0); enter(8'd7, 0); enter(8'd5, 0);
        push_a(t + 5, 3'b000, 1'b1, "t2_wrong_order");
        submit(s);
        enter(8'd3, 0); enter(8'd5, 0); enter(8'd7, 0);
        push_a(t + 9, 3'b001, 1'b0, "t2_retry_win");
        submit(s);
        repeat (2) step();

        // Too many factors, then GAME_OVER abort with no verdict.
        start_round(1'b0, Q_L1, t);
        enter(8'd3, 0); enter(8'd5, 0); enter(8'd7, 0); enter(8'd11, 0);
        push_a(t + 6, 3'b000, 1'b1, "t2_extra");
        submit(s);
        step();
        GAME_OVER = 1'b1;
        step();
        GAME_OVER = 1'b0;
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_time", {16'd0, tl_a}, 32'd0);
        wait_until(t + 130);

        // Enemy wins at level 3.
        start_round(1'b0, Q_L3, t);
        push_a(t + 41, 3'b010, 1'b0, "t3_enemy");
        wait_until(t + 41);
        chk("t3_time_left", {16'd0, tl_a}, 32'd160);
        chk("t3_busy", {31'd0, busy_a}, 32'd1);
        step();
        chk("t3_busy_low", {31'd0, busy_a}, 32'd0);
        step();

        // Correct submit ties with the enemy; last factor in the submit cycle.
        start_round(1'b0, Q_L2, t);
        enter(8'd3, 0); enter(8'd5, 0);
        wait_until(t + 80);
        push_a(t + 81, 3'b011, 1'b0, "t4_tie");
        enter(8'd7, 1);
        repeat (3) step();

        // Short round: timeout draw, then a last-cycle correct submit wins.
        start_round(1'b1, Q_L1, t);
        chk("t5_time_start", {16'd0, tl_b}, 32'd30);
        push_b(t + 31, 3'b011, 1'b0, "t5_timeout");
        wait_until(t + 33);
        start_round(1'b1, Q_L1, t);
        enter(8'd3, 0); enter(8'd5, 0); enter(8'd7, 0);
        wait_until(t + 30);
        push_b(t + 31, 3'b001, 1'b0, "t5_late_win");
        submit(s);
        repeat (3) step();

        // START ignored while GAME_OVER is high.
        GAME_OVER = 1'b1;
        start_round(1'b0, Q_L1, t);
        chk("go_start_busy", {31'd0, busy_a}, 32'd0);
        step();
        GAME_OVER = 1'b0;
        step();

        // Reset mid-round coinciding with a wrong submit.
        start_round(1'b0, Q_L1, t);
        enter(8'd3, 0);
        RST = 1'b1;
        MY_SUBMIT = 1'b1;
        step();
        RST = 1'b0;
        MY_SUBMIT = 1'b0;
        chk("rstmid_judge", {29'd0, judge_a}, 32'd0);
        chk("rstmid_wrong", {31'd0, wrong_a}, 32'd0);
        chk("rstmid_busy", {31'd0, busy_a}, 32'd0);
        chk("rstmid_time", {16'd0, tl_a}, 32'd0);
        wait_until(t + 130);

        chk("A_pending", qa.size(), 32'd0);
        chk("B_pending", qb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/judge_round.md
Name: judge_round

Overview:
- Per-round referee of the factorization game; sits directly upstream of the HP manager and drives its 3-bit HP_IN code.
- Latches the question word from the DB, collects the player's prime factors one per cycle and checks them against the stored answer.
- Runs a level-dependent CPU-opponent timer and a round time limit, then emits a one-cycle verdict: 001 player won, 010 enemy won, 011 draw.

Parameters:
- TIME_LIMIT, 200, round length in cycles (16-bit).
- ENEMY_BASE, 160, base enemy answer delay in cycles.
- ENEMY_STEP, 40, delay reduction per level. Requirement: ENEMY_BASE > 3*ENEMY_STEP.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  pulse; begins a round using DB_IN.
- DB_IN  in  36  question word:
  - [35:34] level.
  - [33:32] factor count minus 1.
  - [31:24]/[23:16]/[15:8]/[7:0] factors f3/f2/f1/f0, ascending from f0; unused lanes 0.
- MY_FACT  in  8  player factor entry.
- MY_VALID  in  1  MY_FACT valid this cycle.
- MY_SUBMIT  in  1  player submits the entered sequence.
- GAME_OVER  in  1  high while the HP manager's RESULT is nonzero.
- JUDGE_OUT  out  3  verdict to the HP manager; 000 except for the one-cycle verdict pulse.
- WRONG  out  1  one-cycle pulse on an incorrect submit.
- BUSY  out  1  high in RUN and DONE.
- TIME_LEFT  out  16  remaining round cycles; 0 when idle.

Behaviour:
- Reset: state IDLE. JUDGE_OUT=000, WRONG=0, BUSY=0, TIME_LEFT=0, entry index=0, mismatch=0. Reset mid-round aborts with no verdict.
- States: IDLE, RUN, DONE.
- IDLE:
  - START && !GAME_OVER latches DB_IN and enters RUN on the next edge. START with GAME_OVER=1 is ignored.
  - On entry: enemy counter E = ENEMY_BASE - L*ENEMY_STEP, where L = level, and level 0 is treated as 1. Round counter T = TIME_LIMIT.
- RUN, each cycle, evaluated in this order:
  - Entry: if MY_VALID and idx<4, compare MY_FACT with lane f[idx]; on inequality set mismatch. If idx==4 on an entry, set mismatch. Then idx++ (saturating at 4).
  - Submit: if MY_SUBMIT, the answer is correct iff mismatch==0 and idx==count. The comparison includes an entry given in the same cycle.
  - Wrong submit: WRONG=1 next cycle; idx and mismatch cleared; round continues.
  - Enemy fires this cycle iff E==1; otherwise E decrements.
  - Timeout fires this cycle iff T==1; otherwise T decrements. TIME_LEFT mirrors T.
- Verdict, with priority in this order:
  - Correct submit and enemy fire in the same cycle -> 011.
  - Correct submit alone -> 001.
  - Enemy fire -> 010, including when timeout fires in the same cycle.
  - Timeout alone -> 011.
- On a verdict: state DONE; JUDGE_OUT holds the code for exactly the following cycle. DONE returns to IDLE next edge, and JUDGE_OUT returns to 000.
- Timing from START accepted at cycle t:
  - Enemy fires at cycle t+E. JUDGE_OUT is valid at t+E+1.
  - A correct submit at cycle s gives JUDGE_OUT at s+1.
- MY_VALID and MY_SUBMIT are ignored outside RUN. START during RUN or DONE is ignored.
- GAME_OVER rising during RUN: abort to IDLE next edge, no verdict, no WRONG.
- JUDGE_OUT[2] is always 0.

Test Plan:
- Level 1, count 2, factors 3,5,7. Enter 3,5,7 on cycles t+1..t+3, submit at t+4 -> JUDGE_OUT=001 at t+5 only; BUSY low at t+6.
- Same question. Enter 3,7,5 and submit -> WRONG pulse, no verdict. Then enter 3,5,7 and submit -> 001. Entering 3,5,7,11 and submitting -> WRONG.
- Level 3, no player input, default parameters -> enemy delay 40; JUDGE_OUT=010 at t+41; TIME_LEFT=160 at that verdict edge.
- Level 2, delay 80. Correct submit with the last entry given in the same cycle as the submit, at cycle t+80 -> 011 at t+81.
- TIME_LIMIT=30, level 1 (delay 120), no input -> 011 at t+31. A correct submit at t+30 -> 001 instead.
- START with GAME_OVER=1 -> stays IDLE. RST asserted mid-RUN -> all outputs 0 next cycle; no verdict ever emitted.
